// File: rtl/acc_read_sched_if.sv
// rtl/acc_read_sched_if.sv - byte-level handshake between the read sequencer and the SPI byte engine
interface acc_read_sched_if;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_cs_n;
    logic       spi_done;
    logic [7:0] spi_rx;

    modport master (
        output spi_start,
        output spi_tx,
        output spi_cs_n,
        input  spi_done,
        input  spi_rx
    );

    modport slave (
        input  spi_start,
        input  spi_tx,
        input  spi_cs_n,
        output spi_done,
        output spi_rx
    );
endinterface

// File: rtl/acc_read_sched.sv
// rtl/acc_read_sched.sv - accelerometer SPI sequencer: one-time config write, periodic burst read, atomic XYZ publish
module acc_read_sched #(
    parameter logic [5:0] INIT_ADDR = 6'h2D,
    parameter logic [7:0] INIT_DATA = 8'h08,
    parameter logic [5:0] DATA_ADDR = 6'h32,
    parameter int         NBYTES    = 6,
    parameter int         PERIOD    = 100000,
    parameter int         TIMEOUT   = 4096,
    parameter int         CS_GAP    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    acc_read_sched_if.master   spi,
    output logic signed [15:0] acc_x,
    output logic signed [15:0] acc_y,
    output logic signed [15:0] acc_z,
    output logic               sample_valid,
    output logic               busy,
    output logic               err
);
    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam int IW = $clog2(NBYTES);

    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
    localparam logic [7:0]    TX_INIT  = {2'b00, INIT_ADDR};
    localparam logic [7:0]    TX_READ  = {2'b11, DATA_ADDR};

    typedef enum logic [3:0] {
        IDLE, GAP, INIT_CMD, INIT_DAT, WAIT, RD_CMD, RD_BYTE, PUBLISH, ERROR
    } state_t;

    state_t        state;
    logic          gap_to_init;
    logic          init_done;
    logic          stop_req;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] per_cnt;
    logic [TW-1:0] to_cnt;
    logic [IW-1:0] idx;
    logic [7:0]    shadow [NBYTES];

    assign busy = ~spi.spi_cs_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            gap_to_init   <= 1'b1;
            init_done     <= 1'b0;
            stop_req      <= 1'b0;
            gap_cnt       <= '0;
            per_cnt       <= '0;
            to_cnt        <= '0;
            idx           <= '0;
            spi.spi_start <= 1'b0;
            spi.spi_tx    <= 8'h00;
            spi.spi_cs_n  <= 1'b1;
            acc_x         <= '0;
            acc_y         <= '0;
            acc_z         <= '0;
            sample_valid  <= 1'b0;
            err           <= 1'b0;
        end else begin
            spi.spi_start <= 1'b0;
            sample_valid  <= 1'b0;
            // Saturating period counter: a late WAIT entry still triggers the read at once
            if (per_cnt != PER_LAST) per_cnt <= per_cnt + PW'(1);

            case (state)
                IDLE: begin
                    if (en) begin
                        state       <= GAP;
                        gap_cnt     <= '0;
                        gap_to_init <= ~init_done;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (!en) begin
                        state <= IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        if (gap_to_init) begin
                            state         <= INIT_CMD;
                            spi.spi_start <= 1'b1;
                            spi.spi_tx    <= TX_INIT;
                            spi.spi_cs_n  <= 1'b0;
                            to_cnt        <= '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (per_cnt == PER_LAST) begin
                        state         <= RD_CMD;
                        per_cnt       <= '0;
                        spi.spi_start <= 1'b1;
                        spi.spi_tx    <= TX_READ;
                        spi.spi_cs_n  <= 1'b0;
                        to_cnt        <= '0;
                    end
                end
                INIT_CMD, INIT_DAT, RD_CMD, RD_BYTE: begin
                    stop_req <= stop_req | ~en;
                    if (spi.spi_done) begin
                        to_cnt <= '0;
                        if (state == INIT_DAT) init_done <= 1'b1;
                        if (stop_req || !en) begin
                            state        <= IDLE;
                            spi.spi_cs_n <= 1'b1;
                            stop_req     <= 1'b0;
                        end else begin
                            case (state)
                                INIT_CMD: begin
                                    state         <= INIT_DAT;
                                    spi.spi_start <= 1'b1;
                                    spi.spi_tx    <= INIT_DATA;
                                end
                                INIT_DAT: begin
                                    state        <= GAP;
                                    spi.spi_cs_n <= 1'b1;
                                    gap_cnt      <= '0;
                                    gap_to_init  <= 1'b0;
                                end
                                RD_CMD: begin
                                    state         <= RD_BYTE;
                                    idx           <= '0;
                                    spi.spi_start <= 1'b1;
                                    spi.spi_tx    <= 8'h00;
                                end
                                default: begin
                                    if (idx == IDX_LAST) begin
                                        // Last byte is taken straight from spi_rx so all axes land together
                                        state        <= PUBLISH;
                                        spi.spi_cs_n <= 1'b1;
                                        acc_x        <= {shadow[1], shadow[0]};
                                        acc_y        <= {shadow[3], shadow[2]};
                                        acc_z        <= {spi.spi_rx, shadow[4]};
                                        sample_valid <= 1'b1;
                                    end else begin
                                        idx           <= idx + IW'(1);
                                        spi.spi_start <= 1'b1;
                                        spi.spi_tx    <= 8'h00;
                                    end
                                end
                            endcase
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state        <= ERROR;
                        spi.spi_cs_n <= 1'b1;
                        err          <= 1'b1;
                        init_done    <= 1'b0;
                        stop_req     <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                PUBLISH: begin
                    state       <= GAP;
                    gap_cnt     <= '0;
                    gap_to_init <= 1'b0;
                end
                ERROR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == RD_BYTE && spi.spi_done) shadow[idx] <= spi.spi_rx;
    end
endmodule

// File: tb/tb_acc_read_sched.sv
// tb/tb_acc_read_sched.sv - randomized self-checking bench for acc_read_sched against a transaction-level model
module tb_acc_read_sched;
    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 256;
    localparam int CS_GAP  = 8;

    typedef struct {
        logic [63:0] tx;
        int          n;
        int          gap;
        logic [47:0] rx;
    } grp_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } smp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [15:0] acc_x;
    logic signed [15:0] acc_y;
    logic signed [15:0] acc_z;
    logic               sample_valid;
    logic               busy;
    logic               err;

    acc_read_sched_if spi_bus ();

    acc_read_sched #(
        .PERIOD (PERIOD),
        .TIMEOUT(TIMEOUT),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .spi         (spi_bus),
        .acc_x       (acc_x),
        .acc_y       (acc_y),
        .acc_z       (acc_z),
        .sample_valid(sample_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hi_run = 0;
    bit          in_grp = 1'b0;
    logic [7:0]  cur_tx[$];
    logic [47:0] cur_rx;
    int          cur_nrx;
    int          cur_gap;
    grp_t        groups[$];
    smp_t        samples[$];
    int          rd_starts[$];
    int          init_cnt = 0;
    int          busy_bad = 0;
    int          rd_idx = 0;
    bit          drop_armed = 1'b0;
    int          drop_cyc = 0;
    int          err_rise = 0;
    logic        prev_err = 1'b0;
    int          lat_min = 20;
    logic [7:0]  rx_plan[$];
    bit          pending = 1'b0;
    int          cnt = 0;
    bit          pend_data = 1'b0;
    logic [7:0]  pend_rx = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic grp_t grp(input int i);
        grp_t g;
        g = '{64'd0, -1, 0, 48'd0};
        if (i >= 0 && i < groups.size()) g = groups[i];
        return g;
    endfunction

    function automatic logic [47:0] smp(input int i);
        if (i >= 0 && i < samples.size()) return {samples[i].x, samples[i].y, samples[i].z};
        return 'x;
    endfunction

    function automatic int rd_at(input int i);
        if (i >= 0 && i < rd_starts.size()) return rd_starts[i];
        return -100000;
    endfunction

    // Data bytes arrive X0,X1,Y0,Y1,Z0,Z1; each axis is the little-endian pair
    function automatic logic [47:0] model_sample(input logic [47:0] rx);
        return {rx[15:0], rx[31:16], rx[47:32]};
    endfunction

    task automatic wait_groups(input int target, input int budget, input string tag);
        int n = 0;
        while (groups.size() < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 64'(groups.size() >= target), 64'd1);
    endtask

    task automatic wait_cur(input int k, input int budget, input string tag);
        int n = 0;
        while (!(in_grp && cur_tx.size() == k && cur_tx[0] == 8'hF2) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    // SPI engine model plus transaction monitor, both on the falling edge
    initial begin
        logic [7:0] tx;
        spi_bus.spi_done = 1'b0;
        spi_bus.spi_rx   = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            spi_bus.spi_done = 1'b0;

            if (spi_bus.spi_cs_n === 1'b0 && !in_grp) begin
                in_grp  = 1'b1;
                cur_tx.delete();
                cur_rx  = '0;
                cur_nrx = 0;
                cur_gap = hi_run;
            end
            if (spi_bus.spi_cs_n === 1'b1) begin
                if (in_grp) begin
                    grp_t g;
                    g.tx = '0;
                    foreach (cur_tx[i]) if (i < 8) g.tx[8*i +: 8] = cur_tx[i];
                    g.n   = cur_tx.size();
                    g.gap = cur_gap;
                    g.rx  = cur_rx;
                    groups.push_back(g);
                    in_grp = 1'b0;
                end
                hi_run++;
            end else begin
                hi_run = 0;
            end

            if (busy !== ~spi_bus.spi_cs_n) busy_bad++;
            if (sample_valid === 1'b1) samples.push_back('{acc_x, acc_y, acc_z});
            if (err === 1'b1 && prev_err !== 1'b1) err_rise = cyc;
            prev_err = err;

            if (rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (cnt == 0) begin
                        spi_bus.spi_done = 1'b1;
                        spi_bus.spi_rx   = pend_rx;
                        pending          = 1'b0;
                        if (pend_data && cur_nrx < 6) begin
                            cur_rx[8*cur_nrx +: 8] = pend_rx;
                            cur_nrx++;
                        end
                    end else begin
                        cnt--;
                    end
                end
                if (spi_bus.spi_start === 1'b1) begin
                    tx = spi_bus.spi_tx;
                    cur_tx.push_back(tx);
                    if (tx == 8'hF2) rd_starts.push_back(cyc);
                    if (tx == 8'h2D) init_cnt++;
                    rd_idx = (tx == 8'h00) ? rd_idx + 1 : 0;
                    if (drop_armed && tx == 8'h00 && rd_idx == 3) begin
                        drop_armed = 1'b0;
                        drop_cyc   = cyc;
                    end else begin
                        pending   = 1'b1;
                        cnt       = $urandom_range(20, lat_min) - 1;
                        pend_data = (tx == 8'h00);
                        if (pend_data && rx_plan.size() > 0) pend_rx = rx_plan.pop_front();
                        else pend_rx = 8'($urandom);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_cs_n", 64'(spi_bus.spi_cs_n), 64'd1);
        check("reset_start", 64'(spi_bus.spi_start), 64'd0);
        check("reset_tx", 64'(spi_bus.spi_tx), 64'd0);
        check("reset_acc", 64'({acc_x, acc_y, acc_z}), 64'd0);
        check("reset_sample_valid", 64'(sample_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err), 64'd0);

        rx_plan = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        rst = 1'b0;
        en  = 1'b1;
        wait_groups(2, 800, "wait_init_and_first_read");
        check("init_bytes", grp(0).tx, 64'h082D);
        check("init_len", 64'(grp(0).n), 64'd2);
        check("read_bytes", grp(1).tx, 64'hF2);
        check("read_len", 64'(grp(1).n), 64'd7);
        check("cs_gap_before_read", 64'(grp(1).gap >= CS_GAP), 64'd1);
        check("first_sample_count", 64'(samples.size()), 64'd1);
        check("first_sample", 64'(smp(0)), 64'h0201_0403_0605);

        lat_min = 3;
        wait_groups(4, 800, "wait_periodic_reads");
        check("period_1", 64'(rd_at(1) - rd_at(0)), 64'(PERIOD));
        check("period_2", 64'(rd_at(2) - rd_at(1)), 64'(PERIOD));
        check("no_init_rewrite", 64'(init_cnt), 64'd1);
        check("sample_count_3", 64'(samples.size()), 64'd3);
        check("sample_2", 64'(smp(1)), 64'(model_sample(grp(2).rx)));
        check("sample_3", 64'(smp(2)), 64'(model_sample(grp(3).rx)));

        drop_armed = 1'b1;
        begin
            int n = 0;
            while (err !== 1'b1 && n < 1500) begin
                @(negedge clk); #1;
                n++;
            end
        end
        check("err_set", 64'(err), 64'd1);
        check("timeout_latency", 64'(err_rise - drop_cyc), 64'(TIMEOUT));
        check("err_cs_high", 64'(spi_bus.spi_cs_n), 64'd1);
        check("err_no_sample", 64'(samples.size()), 64'd3);
        check("err_partial_len", 64'(grp(4).n), 64'd4);
        wait_groups(6, 400, "wait_reinit_after_err");
        check("reinit_bytes", grp(5).tx, 64'h082D);
        check("err_sticky", 64'(err), 64'd1);

        wait_cur(2, 600, "wait_read_byte2");
        en = 1'b0;
        wait_groups(7, 200, "wait_stop_close");
        check("stop_group_len", 64'(grp(6).n), 64'd2);
        repeat (300) @(negedge clk);
        #1;
        check("parked_no_new_group", 64'(groups.size()), 64'd7);
        check("parked_cs_high", 64'(spi_bus.spi_cs_n), 64'd1);
        check("parked_acc_unchanged", 64'({acc_x, acc_y, acc_z}), 64'(model_sample(grp(3).rx)));
        check("parked_no_sample", 64'(samples.size()), 64'd3);
        en = 1'b1;
        wait_groups(8, 600, "wait_resume_read");
        check("resume_read_bytes", grp(7).tx, 64'hF2);
        check("resume_read_len", 64'(grp(7).n), 64'd7);
        check("resume_no_init", 64'(init_cnt), 64'd2);
        check("sample_4", 64'(smp(3)), 64'(model_sample(grp(7).rx)));

        wait_cur(4, 600, "wait_read_byte4");
        rst = 1'b1;
        #1;
        check("rst_async_cs_n", 64'(spi_bus.spi_cs_n), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(spi_bus.spi_start), 64'd0);
        check("rst_tx", 64'(spi_bus.spi_tx), 64'd0);
        check("rst_acc", 64'({acc_x, acc_y, acc_z}), 64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_err_cleared", 64'(err), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        wait_groups(10, 400, "wait_reinit_after_rst");
        check("rst_partial_len", 64'(grp(8).n), 64'd4);
        check("rst_reinit_bytes", grp(9).tx, 64'h082D);
        check("busy_tracks_cs", 64'(busy_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
